// File: rtl/clock_pkg.sv
// Shared types and helpers for the multi-alarm timekeeping core.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = v / 7'd10;
        ones = v - tens * 7'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: IDLE/RING/SNOOZE state machine with ring-timeout and snooze counters.
module alarm_channel
    import clock_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [HOUR_W+MIN_W-1:0] hm_i,
    input  logic                    tick_i,
    input  logic                    sec_wrap_i,
    input  logic [HOUR_W-1:0]       hour_nx_i,
    input  logic [MIN_W-1:0]        min_nx_i,
    input  logic                    snooze_i,
    output logic                    ring_o
);

    localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
    localparam int RW = $clog2(RING_SEC + 1);
    localparam int SW = $clog2(SNOOZE_TICKS + 1);

    alarm_state_t  state_q;
    logic [RW-1:0] ring_cnt_q;
    logic [SW-1:0] snz_cnt_q;
    logic          ring_q;
    logic          valid_set;
    logic          match;

    // Match on the tick that carries the clock into the alarm's HH:MM:00.
    assign valid_set = (hm_i[HOUR_W+MIN_W-1:MIN_W] <= 5'd23) && (hm_i[MIN_W-1:0] <= 6'd59);
    assign match     = en_i && sec_wrap_i && valid_set && (hm_i == {hour_nx_i, min_nx_i});
    assign ring_o    = ring_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            ring_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match) begin
                        state_q    <= RING;
                        ring_cnt_q <= RW'(RING_SEC);
                        ring_q     <= 1'b1;
                    end
                end
                RING: begin
                    if (!en_i) begin
                        state_q <= IDLE;
                        ring_q  <= 1'b0;
                    end else if (snooze_i) begin
                        state_q   <= SNOOZE;
                        snz_cnt_q <= SW'(SNOOZE_TICKS);
                        ring_q    <= 1'b0;
                    end else if (tick_i) begin
                        if (ring_cnt_q < RW'(2)) begin
                            state_q <= IDLE;
                            ring_q  <= 1'b0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q - RW'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (!en_i) begin
                        state_q <= IDLE;
                    end else if (tick_i) begin
                        if (snz_cnt_q < SW'(2)) begin
                            state_q    <= RING;
                            ring_cnt_q <= RW'(RING_SEC);
                            ring_q     <= 1'b1;
                        end else begin
                            snz_cnt_q <= snz_cnt_q - SW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ring_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_alarm_clock_core.sv
// HH:MM:SS timekeeper with button adjust, N alarm channels, hourly chime and BCD display word.
module multi_alarm_clock_core
    import clock_pkg::*;
#(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int N_ALARM     = 4,
    parameter int RING_SEC    = 60,
    parameter int SNOOZE_MIN  = 5,
    parameter int CHIME_SEC   = 4
) (
    input  logic                   CLK100MHZ,
    input  logic                   rst,
    input  logic                   mode24,
    input  logic                   adj_en,
    input  logic                   adj_sel,
    input  logic                   adj_dir,
    input  logic                   btn,
    input  logic                   snooze,
    input  logic [N_ALARM-1:0]     alarm_en,
    input  logic [11*N_ALARM-1:0]  alarm_hm,
    output logic [HOUR_W-1:0]      hour24,
    output logic [MIN_W-1:0]       minute,
    output logic [MIN_W-1:0]       second,
    output logic [31:0]            disp_data,
    output logic [N_ALARM-1:0]     alarm_ring,
    output logic                   chime,
    output logic                   tick_1hz
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CW = $clog2(CHIME_SEC + 1);

    logic [PW-1:0]     pre_q, pre_d;
    logic              tick;
    logic              tick_1hz_q;
    logic [2:0]        btn_sync_q, snz_sync_q;
    logic              btn_edge, snz_edge;
    logic [HOUR_W-1:0] hour_q, hour_d, hour_nx;
    logic [MIN_W-1:0]  min_q, min_d, min_nx;
    logic [MIN_W-1:0]  sec_q, sec_d, sec_nx;
    logic              sec_wrap, min_wrap;
    logic [CW-1:0]     chime_q, chime_d;
    logic [HOUR_W-1:0] hour_disp;
    logic [3:0]        ring_idx;

    always_comb begin
        tick  = 1'b0;
        pre_d = pre_q + PW'(1);
        if (adj_en) begin
            pre_d = '0;
        end else if (pre_q == PW'(TICK_CYCLES - 1)) begin
            tick  = 1'b1;
            pre_d = '0;
        end
    end

    // Bits [1:0] synchronise the raw button, bit [2] holds the previous level for edge detect.
    assign btn_edge = btn_sync_q[1] & ~btn_sync_q[2];
    assign snz_edge = snz_sync_q[1] & ~snz_sync_q[2];

    assign sec_wrap = tick && (sec_q == 6'd59);
    assign min_wrap = sec_wrap && (min_q == 6'd59);
    assign sec_nx   = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    assign min_nx   = (sec_q == 6'd59) ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1) : min_q;
    assign hour_nx  = (sec_q == 6'd59 && min_q == 6'd59) ?
                      ((hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1) : hour_q;

    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (adj_en) begin
            sec_d = '0;
            if (btn_edge) begin
                if (adj_sel)
                    hour_d = adj_dir ? ((hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1)
                                     : ((hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1);
                else
                    min_d = adj_dir ? ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1)
                                    : ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1);
            end
        end else if (tick) begin
            sec_d  = sec_nx;
            min_d  = min_nx;
            hour_d = hour_nx;
        end
    end

    always_comb begin
        chime_d = chime_q;
        if (min_wrap)
            chime_d = CW'(CHIME_SEC);
        else if (tick && chime_q != '0)
            chime_d = chime_q - CW'(1);
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            pre_q      <= '0;
            tick_1hz_q <= 1'b0;
            btn_sync_q <= '0;
            snz_sync_q <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            chime_q    <= '0;
        end else begin
            pre_q      <= pre_d;
            tick_1hz_q <= (pre_d < PW'(TICK_CYCLES / 2));
            btn_sync_q <= {btn_sync_q[1:0], btn};
            snz_sync_q <= {snz_sync_q[1:0], snooze};
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            chime_q    <= chime_d;
        end
    end

    for (genvar k = 0; k < N_ALARM; k++) begin : g_alarm
        alarm_channel #(
            .RING_SEC   (RING_SEC),
            .SNOOZE_MIN (SNOOZE_MIN)
        ) u_ch (
            .clk_i      (CLK100MHZ),
            .rst_i      (rst),
            .en_i       (alarm_en[k]),
            .hm_i       (alarm_hm[11*k +: 11]),
            .tick_i     (tick),
            .sec_wrap_i (sec_wrap),
            .hour_nx_i  (hour_nx),
            .min_nx_i   (min_nx),
            .snooze_i   (snz_edge),
            .ring_o     (alarm_ring[k])
        );
    end

    always_comb begin
        hour_disp = hour_q;
        if (!mode24) begin
            if (hour_q == 5'd0)
                hour_disp = 5'd12;
            else if (hour_q > 5'd12)
                hour_disp = hour_q - 5'd12;
        end
        ring_idx = '0;
        for (int k = N_ALARM - 1; k >= 0; k--)
            if (alarm_ring[k]) ring_idx = 4'(k + 1);
    end

    assign disp_data = {bin2bcd({2'b00, hour_disp}), bin2bcd({1'b0, min_q}), bin2bcd({1'b0, sec_q}),
                        (hour_q >= 5'd12), 3'b000, ring_idx};
    assign hour24    = hour_q;
    assign minute    = min_q;
    assign second    = sec_q;
    assign chime     = (chime_q != '0);
    assign tick_1hz  = tick_1hz_q;

endmodule

// File: tb/tb_multi_alarm_clock_core.sv
// Directed bench for multi_alarm_clock_core with a 4-cycle second tick.
module tb_multi_alarm_clock_core;

    logic        clk = 1'b0;
    logic        rst, mode24, adj_en, adj_sel, adj_dir, btn, snooze;
    logic [3:0]  alarm_en;
    logic [43:0] alarm_hm;
    logic [4:0]  hour24;
    logic [5:0]  minute, second;
    logic [31:0] disp_data;
    logic [3:0]  alarm_ring;
    logic        chime, tick_1hz;

    int vectors = 0;
    int miscompares = 0;

    multi_alarm_clock_core #(
        .TICK_CYCLES (4),
        .N_ALARM     (4),
        .RING_SEC    (60),
        .SNOOZE_MIN  (5),
        .CHIME_SEC   (4)
    ) dut (
        .CLK100MHZ  (clk),
        .rst        (rst),
        .mode24     (mode24),
        .adj_en     (adj_en),
        .adj_sel    (adj_sel),
        .adj_dir    (adj_dir),
        .btn        (btn),
        .snooze     (snooze),
        .alarm_en   (alarm_en),
        .alarm_hm   (alarm_hm),
        .hour24     (hour24),
        .minute     (minute),
        .second     (second),
        .disp_data  (disp_data),
        .alarm_ring (alarm_ring),
        .chime      (chime),
        .tick_1hz   (tick_1hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        btn = 1'b1;
        cyc(4);
        btn = 1'b0;
        cyc(4);
    endtask

    task automatic set_hm(input int k, input logic [4:0] h, input logic [5:0] m);
        alarm_hm[11*k +: 11] = {h, m};
    endtask

    initial begin
        rst = 1'b1; mode24 = 1'b1; adj_en = 1'b0; adj_sel = 1'b0; adj_dir = 1'b0;
        btn = 1'b0; snooze = 1'b0; alarm_en = '0; alarm_hm = '0;
        cyc(3);
        chk("rst_hour", hour24, 0);
        chk("rst_min", minute, 0);
        chk("rst_sec", second, 0);
        chk("rst_disp24", disp_data, 32'h0000_0000);
        chk("rst_ring", alarm_ring, 0);
        chk("rst_chime", chime, 0);
        chk("rst_tick1hz", tick_1hz, 0);

        // Field adjust: minute 0 -1 wraps to 59 without touching the hour, then hour 0 -1 -> 23
        rst = 1'b0;
        adj_en = 1'b1; adj_sel = 1'b0; adj_dir = 1'b1;
        press();
        chk("adj_min_wrap", minute, 59);
        chk("adj_hour_kept", hour24, 0);
        adj_sel = 1'b1;
        press();
        chk("adj_hour_wrap", hour24, 23);
        cyc(12);
        chk("adj_frozen_sec", second, 0);
        chk("disp24_2359", disp_data, 32'h2359_0080);
        mode24 = 1'b0; #1;
        chk("disp12_1159", disp_data, 32'h1159_0080);
        mode24 = 1'b1;

        // Day rollover and chime
        @(negedge clk);
        adj_en = 1'b0;
        cyc(236);
        chk("pre_roll", {hour24, minute, second}, {5'd23, 6'd59, 6'd59});
        chk("pre_roll_chime", chime, 0);
        cyc(4);
        chk("day_roll", {hour24, minute, second}, {5'd0, 6'd0, 6'd0});
        chk("chime_on", chime, 1);
        cyc(12);
        chk("chime_3ticks", chime, 1);
        cyc(4);
        chk("chime_off", chime, 0);
        chk("tick1hz_hi", tick_1hz, 1);
        cyc(2);
        chk("tick1hz_lo", tick_1hz, 0);
        cyc(2);

        // Single alarm: ch0 07:30, run from 07:29:58
        adj_en = 1'b1; adj_sel = 1'b1; adj_dir = 1'b0;
        repeat (7) press();
        adj_sel = 1'b0;
        repeat (29) press();
        set_hm(0, 5'd7, 6'd30);
        alarm_en = 4'b0001;
        adj_en = 1'b0;
        cyc(232);
        chk("t_072958", {hour24, minute, second}, {5'd7, 6'd29, 6'd58});
        cyc(7);
        chk("ring_before_tick", alarm_ring, 4'b0000);
        cyc(1);
        chk("ring_start", alarm_ring, 4'b0001);
        chk("disp_ring0", disp_data, 32'h0730_0001);
        cyc(236);
        chk("ring_59ticks", alarm_ring, 4'b0001);
        cyc(4);
        chk("ring_timeout", alarm_ring, 4'b0000);
        alarm_en = 4'b0000;

        // Snooze on ch1 (07:32)
        set_hm(1, 5'd7, 6'd32);
        alarm_en = 4'b0010;
        cyc(240);
        chk("ch1_ring", alarm_ring, 4'b0010);
        chk("disp_idx2", disp_data, 32'h0732_0002);
        snooze = 1'b1;
        cyc(4);
        chk("ch1_snoozed", alarm_ring, 4'b0000);
        snooze = 1'b0;
        cyc(1192);
        chk("snooze_299", alarm_ring, 4'b0000);
        cyc(4);
        chk("snooze_rering", alarm_ring, 4'b0010);
        snooze = 1'b1;
        cyc(4);
        snooze = 1'b0;
        chk("snooze_again", alarm_ring, 4'b0000);
        alarm_en = 4'b0000;
        cyc(4);
        alarm_en = 4'b0010;
        cyc(1200);
        chk("snooze_cancel", alarm_ring, 4'b0000);
        alarm_en = 4'b0000;

        // ch0 and ch2 at 08:00, snooze on the final ring tick
        set_hm(0, 5'd8, 6'd0);
        set_hm(2, 5'd8, 6'd0);
        alarm_en = 4'b0101;
        cyc(4304);
        chk("t_075958", {hour24, minute, second}, {5'd7, 6'd59, 6'd58});
        cyc(8);
        chk("dual_ring", alarm_ring, 4'b0101);
        chk("disp_0800", disp_data, 32'h0800_0001);
        chk("chime_0800", chime, 1);
        cyc(237);
        chk("dual_idx1", disp_data[3:0], 4'd1);
        chk("dual_last", alarm_ring, 4'b0101);
        snooze = 1'b1;
        cyc(3);
        snooze = 1'b0;
        chk("dual_snoozed", alarm_ring, 4'b0000);
        chk("dual_idx0", disp_data[3:0], 4'd0);
        cyc(1196);
        chk("dual_snz_wait", alarm_ring, 4'b0000);
        cyc(4);
        chk("dual_rering", alarm_ring, 4'b0101);

        // Reset mid-ring in 12 h mode, then out-of-range alarm 24:10
        mode24 = 1'b0; #1;
        chk("disp12_0806", disp_data, 32'h0806_0001);
        rst = 1'b1; #1;
        chk("arst_ring", alarm_ring, 4'b0000);
        chk("arst_time", {hour24, minute, second}, 17'd0);
        chk("arst_tick1hz", tick_1hz, 0);
        chk("arst_chime", chime, 0);
        chk("arst_disp12", disp_data, 32'h1200_0000);
        @(negedge clk);
        rst = 1'b0;
        alarm_en = 4'b1000;
        set_hm(3, 5'd24, 6'd10);
        adj_en = 1'b1; adj_sel = 1'b0; adj_dir = 1'b0;
        repeat (9) press();
        adj_en = 1'b0;
        cyc(240);
        chk("t_001000", {hour24, minute, second}, {5'd0, 6'd10, 6'd0});
        chk("oor_no_ring", alarm_ring, 4'b0000);
        chk("disp12_1210", disp_data, 32'h1210_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
